// File: rtl/memory_writeback_stage_pkg.sv
// Shared configuration and type definitions for the memory/writeback stage.
// ConfigPack holds build-time sizes; StaticPack holds the opcode and FSM enums.
package ConfigPack;
    localparam int ADDRESS_WIDTH = 32;
endpackage

package StaticPack;
    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LH   = 4'd2,
        LW   = 4'd3,
        LBU  = 4'd4,
        LHU  = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } memoryOp_t;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        REQUEST       = 2'd1,
        WAIT_RESPONSE = 2'd2
    } MEMORY_STATE_t;

    function automatic logic is_load_op(input memoryOp_t op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic is_store_op(input memoryOp_t op);
        return op inside {SB, SH, SW};
    endfunction
endpackage

// File: rtl/memory_writeback_stage_aligner.sv
// Combinational byte-lane logic: misalignment detection, store strobe/lane
// replication, and load byte/half extraction with sign or zero extension.
module load_store_aligner
    import StaticPack::*;
(
    input  memoryOp_t   op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        misaligned_o,
    output logic [3:0]  strobe_o,
    output logic [31:0] store_word_o,
    output logic [31:0] load_data_o
);
    logic [7:0]  word_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_bytes[gi] = load_word_i[gi*8 +: 8];
        end
    endgenerate

    assign sel_byte = word_bytes[lane_i];
    assign sel_half = lane_i[1] ? load_word_i[31:16] : load_word_i[15:0];

    always_comb begin
        is_load_o    = is_load_op(op_i);
        is_store_o   = is_store_op(op_i);
        misaligned_o = 1'b0;
        strobe_o     = 4'b0000;
        store_word_o = 32'h0;
        load_data_o  = load_word_i;
        case (op_i)
            LB:  load_data_o = {{24{sel_byte[7]}}, sel_byte};
            LBU: load_data_o = {24'h0, sel_byte};
            LH: begin
                misaligned_o = lane_i[0];
                load_data_o  = {{16{sel_half[15]}}, sel_half};
            end
            LHU: begin
                misaligned_o = lane_i[0];
                load_data_o  = {16'h0, sel_half};
            end
            LW:  misaligned_o = |lane_i;
            SB: begin
                strobe_o     = 4'b0001 << lane_i;
                store_word_o = {4{store_data_i[7:0]}};
            end
            SH: begin
                misaligned_o = lane_i[0];
                strobe_o     = 4'b0011 << lane_i;
                store_word_o = {2{store_data_i[15:0]}};
            end
            SW: begin
                misaligned_o = |lane_i;
                strobe_o     = 4'b1111;
                store_word_o = store_data_i;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/memory_writeback_stage.sv
// Final pipeline stage: retires ALU results, runs loads/stores over a
// valid/ready data-memory port, and emits one registered writeback beat.
module memory_writeback_stage
    import StaticPack::*;
#(
    parameter int ADDRESS_WIDTH = ConfigPack::ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     executeValid,
    output logic                     executeReady,
    input  logic [31:0]              executeResult,
    input  logic [31:0]              executeStoreData,
    input  memoryOp_t                executeMemoryOp,
    input  logic                     executeDestinationEnable,
    input  logic [4:0]               executeWriteAddress,
    output logic                     dataRequestValid,
    input  logic                     dataRequestReady,
    output logic [ADDRESS_WIDTH-1:0] dataAddress,
    output logic                     dataWriteEnable,
    output logic [3:0]               dataWriteStrobe,
    output logic [31:0]              dataWriteData,
    input  logic                     dataResponseValid,
    input  logic [31:0]              dataResponseData,
    output logic                     destinationEnable,
    output logic [4:0]               writeAddress,
    output logic [31:0]              writeData,
    output logic                     memoryWritebackValid,
    output logic                     misalignedException,
    output logic [31:0]              misalignedAddress
);
    MEMORY_STATE_t state_q, state_d;
    memoryOp_t     op_q, op_d;
    logic [1:0]    lane_q, lane_d;
    logic          rd_enable_q, rd_enable_d;

    logic                     req_valid_q, req_valid_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [3:0]               strobe_q, strobe_d;
    logic [31:0]              wdata_q, wdata_d;

    logic        beat_valid_q, beat_valid_d;
    logic        dest_en_q, dest_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        exc_q, exc_d;
    logic [31:0] mis_addr_q, mis_addr_d;

    // The aligner serves the incoming instruction while idle and the
    // latched load while waiting, so one instance covers both uses.
    memoryOp_t   align_op;
    logic [1:0]  align_lane;
    logic        is_load, is_store, misaligned;
    logic [3:0]  align_strobe;
    logic [31:0] align_store_word, align_load_data;
    logic        writes_rd;

    assign align_op   = (state_q == IDLE) ? executeMemoryOp : op_q;
    assign align_lane = (state_q == IDLE) ? executeResult[1:0] : lane_q;
    assign writes_rd  = executeDestinationEnable && (executeWriteAddress != 5'd0);

    load_store_aligner u_aligner (
        .op_i         (align_op),
        .lane_i       (align_lane),
        .store_data_i (executeStoreData),
        .load_word_i  (dataResponseData),
        .is_load_o    (is_load),
        .is_store_o   (is_store),
        .misaligned_o (misaligned),
        .strobe_o     (align_strobe),
        .store_word_o (align_store_word),
        .load_data_o  (align_load_data)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        rd_enable_d  = rd_enable_q;
        req_valid_d  = req_valid_q;
        addr_d       = addr_q;
        we_d         = we_q;
        strobe_d     = strobe_q;
        wdata_d      = wdata_q;
        beat_valid_d = 1'b0;
        dest_en_d    = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        exc_d        = 1'b0;
        mis_addr_d   = mis_addr_q;
        case (state_q)
            IDLE: begin
                if (executeValid) begin
                    wr_addr_d   = executeWriteAddress;
                    rd_enable_d = writes_rd;
                    if (!is_load && !is_store) begin
                        beat_valid_d = 1'b1;
                        dest_en_d    = writes_rd;
                        wr_data_d    = executeResult;
                    end else if (misaligned) begin
                        beat_valid_d = 1'b1;
                        exc_d        = 1'b1;
                        mis_addr_d   = executeResult;
                    end else begin
                        state_d     = REQUEST;
                        req_valid_d = 1'b1;
                        addr_d      = {executeResult[ADDRESS_WIDTH-1:2], 2'b00};
                        we_d        = is_store;
                        strobe_d    = align_strobe;
                        wdata_d     = align_store_word;
                        op_d        = executeMemoryOp;
                        lane_d      = executeResult[1:0];
                    end
                end
            end
            REQUEST: begin
                if (dataRequestReady) begin
                    req_valid_d = 1'b0;
                    if (we_q) begin
                        state_d      = IDLE;
                        beat_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT_RESPONSE;
                    end
                end
            end
            WAIT_RESPONSE: begin
                if (dataResponseValid) begin
                    state_d      = IDLE;
                    beat_valid_d = 1'b1;
                    dest_en_d    = rd_enable_q;
                    wr_data_d    = align_load_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= NONE;
            lane_q       <= 2'b00;
            rd_enable_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            strobe_q     <= 4'b0000;
            wdata_q      <= 32'h0;
            beat_valid_q <= 1'b0;
            dest_en_q    <= 1'b0;
            wr_addr_q    <= 5'd0;
            wr_data_q    <= 32'h0;
            exc_q        <= 1'b0;
            mis_addr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            rd_enable_q  <= rd_enable_d;
            req_valid_q  <= req_valid_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            strobe_q     <= strobe_d;
            wdata_q      <= wdata_d;
            beat_valid_q <= beat_valid_d;
            dest_en_q    <= dest_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            exc_q        <= exc_d;
            mis_addr_q   <= mis_addr_d;
        end
    end

    assign executeReady         = (state_q == IDLE);
    assign dataRequestValid     = req_valid_q;
    assign dataAddress          = addr_q;
    assign dataWriteEnable      = we_q;
    assign dataWriteStrobe      = strobe_q;
    assign dataWriteData        = wdata_q;
    assign destinationEnable    = dest_en_q;
    assign writeAddress         = wr_addr_q;
    assign writeData            = wr_data_q;
    assign memoryWritebackValid = beat_valid_q;
    assign misalignedException  = exc_q;
    assign misalignedAddress    = mis_addr_q;
endmodule

// File: tb/tb_memory_writeback_stage.sv
// Bench for memory_writeback_stage: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model with a memory array.
module tb_memory_writeback_stage;
    import StaticPack::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        executeValid;
    logic        executeReady;
    logic [31:0] executeResult;
    logic [31:0] executeStoreData;
    memoryOp_t   executeMemoryOp;
    logic        executeDestinationEnable;
    logic [4:0]  executeWriteAddress;
    logic        dataRequestValid;
    logic        dataRequestReady;
    logic [31:0] dataAddress;
    logic        dataWriteEnable;
    logic [3:0]  dataWriteStrobe;
    logic [31:0] dataWriteData;
    logic        dataResponseValid;
    logic [31:0] dataResponseData;
    logic        destinationEnable;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic        memoryWritebackValid;
    logic        misalignedException;
    logic [31:0] misalignedAddress;

    always #5 clock = ~clock;

    memory_writeback_stage dut (
        .clock(clock), .reset(reset),
        .executeValid(executeValid), .executeReady(executeReady),
        .executeResult(executeResult), .executeStoreData(executeStoreData),
        .executeMemoryOp(executeMemoryOp),
        .executeDestinationEnable(executeDestinationEnable),
        .executeWriteAddress(executeWriteAddress),
        .dataRequestValid(dataRequestValid), .dataRequestReady(dataRequestReady),
        .dataAddress(dataAddress), .dataWriteEnable(dataWriteEnable),
        .dataWriteStrobe(dataWriteStrobe), .dataWriteData(dataWriteData),
        .dataResponseValid(dataResponseValid), .dataResponseData(dataResponseData),
        .destinationEnable(destinationEnable), .writeAddress(writeAddress),
        .writeData(writeData), .memoryWritebackValid(memoryWritebackValid),
        .misalignedException(misalignedException), .misalignedAddress(misalignedAddress)
    );

    typedef struct {
        int          due;
        bit          is_mem;
        bit          de;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          exc;
        logic [31:0] maddr;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  strobe;
        logic [31:0] data;
    } req_t;

    beat_t       exp_q[$];
    req_t        req_q[$];
    logic [31:0] mem [64];
    int          cycle = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mem_outstanding = 0;
    int          mem_due = -1;
    logic [31:0] exp_mis_addr = 32'h0;

    int ready_hold = 0;
    bit ready_rand = 0;
    int resp_delay_fixed = 0;
    bit spurious_en = 0;
    bit spurious_force = 0;

    bit          resp_pending = 0;
    int          resp_wait = 0;
    logic [31:0] resp_word = 32'h0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int op_size(input memoryOp_t op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input memoryOp_t op, input int off, input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] v;
        sh = word >> (8 * off);
        case (op)
            LB:  begin v = sh & 32'hFF;   if (v[7])  v = v | 32'hFFFF_FF00; end
            LBU: v = sh & 32'hFF;
            LH:  begin v = sh & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
            LHU: v = sh & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    // Monitor and memory responder: compares every cycle, then drives the memory side.
    always @(negedge clock) begin
        beat_t e;
        req_t  r;
        int    due;
        if (!reset) begin
            if (memoryWritebackValid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat: got beat expected none (cycle %0d)", cycle);
                end else begin
                    e = exp_q.pop_front();
                    due = e.is_mem ? mem_due : e.due;
                    check("beat_cycle", cycle, due);
                    check("beat_dest_en", {31'h0, destinationEnable}, {31'h0, e.de});
                    check("beat_exception", {31'h0, misalignedException}, {31'h0, e.exc});
                    if (e.de) begin
                        check("beat_wr_addr", {27'h0, writeAddress}, {27'h0, e.wa});
                        check("beat_wr_data", writeData, e.wd);
                    end
                    if (e.exc) exp_mis_addr = e.maddr;
                    if (e.is_mem) mem_outstanding = 0;
                end
            end else begin
                check("idle_dest_en", {31'h0, destinationEnable}, 32'h0);
                check("idle_exception", {31'h0, misalignedException}, 32'h0);
            end
            check("misaligned_addr", misalignedAddress, exp_mis_addr);
            check("execute_ready", {31'h0, executeReady}, {31'h0, !mem_outstanding});
            if (dataRequestValid) begin
                if (req_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_request: got request expected none (cycle %0d)", cycle);
                end else begin
                    r = req_q[0];
                    check("req_addr", dataAddress, r.addr);
                    check("req_we", {31'h0, dataWriteEnable}, {31'h0, r.we});
                    check("req_strobe", {28'h0, dataWriteStrobe}, {28'h0, r.strobe});
                    if (r.we) check("req_data", dataWriteData, r.data);
                end
            end
        end

        dataResponseValid = 1'b0;
        if (resp_pending) begin
            if (resp_wait == 0) begin
                dataResponseValid = 1'b1;
                dataResponseData  = resp_word;
                resp_pending      = 0;
                mem_due           = cycle + 1;
            end else begin
                resp_wait--;
            end
        end else if (!dataRequestValid && (spurious_force || (spurious_en && $urandom_range(0, 9) == 0))) begin
            dataResponseValid = 1'b1;
            dataResponseData  = $urandom;
            spurious_force    = 0;
        end

        if (dataRequestValid && ready_hold > 0) begin
            dataRequestReady = 1'b0;
            ready_hold--;
        end else begin
            dataRequestReady = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end

        if (!reset && dataRequestValid && dataRequestReady && req_q.size() > 0) begin
            r = req_q.pop_front();
            if (!r.we) begin
                resp_pending = 1;
                resp_wait    = (resp_delay_fixed >= 0) ? resp_delay_fixed : $urandom_range(0, 3);
                resp_word    = mem[r.addr[7:2]];
            end else begin
                mem_due = cycle + 1;
            end
        end
    end

    // Presents one instruction (called at a negedge), records the model's expectations.
    task automatic issue(input memoryOp_t op, input logic [31:0] res, input logic [31:0] sd,
                         input bit de, input logic [4:0] rd, output int acc);
        int          waited;
        int          size;
        int          off;
        beat_t       e;
        req_t        r;
        logic [5:0]  idx;
        waited = 0;
        while (!executeReady && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (!executeReady) begin
            checks++; failures++;
            $display("FAIL issue_timeout: got executeReady=0 expected 1 within 200 cycles");
            acc = -1;
            return;
        end
        executeValid             = 1'b1;
        executeMemoryOp          = op;
        executeResult            = res;
        executeStoreData         = sd;
        executeDestinationEnable = de;
        executeWriteAddress      = rd;
        acc = cycle;
        @(posedge clock);
        size = op_size(op);
        off  = int'(res[1:0]);
        idx  = res[7:2];
        e.due = acc + 1; e.is_mem = 0; e.de = 0; e.wa = rd; e.wd = res; e.exc = 0; e.maddr = res;
        if (size == 0) begin
            e.de = de && (rd != 5'd0);
            exp_q.push_back(e);
        end else if ((off % size) != 0) begin
            e.exc = 1;
            exp_q.push_back(e);
        end else begin
            e.is_mem        = 1;
            mem_due         = -1;
            mem_outstanding = 1;
            r.addr = res & 32'hFFFF_FFFC;
            r.we   = (op == SB || op == SH || op == SW);
            if (r.we) begin
                if (size == 1) begin
                    r.strobe = 4'(1 << off);
                    r.data   = (sd & 32'hFF) * 32'h0101_0101;
                end else if (size == 2) begin
                    r.strobe = 4'(3 << off);
                    r.data   = (sd & 32'hFFFF) * 32'h0001_0001;
                end else begin
                    r.strobe = 4'hF;
                    r.data   = sd;
                end
                for (int b = 0; b < 4; b++)
                    if (r.strobe[b]) mem[idx][8*b +: 8] = r.data[8*b +: 8];
            end else begin
                r.strobe = 4'h0;
                r.data   = 32'h0;
                e.de     = de && (rd != 5'd0);
                e.wd     = load_val(op, off, mem[idx]);
            end
            req_q.push_back(r);
            exp_q.push_back(e);
        end
        @(negedge clock);
        executeValid = 1'b0;
    endtask

    task automatic wait_beat(output bit de, output logic [31:0] wd, output int at);
        for (int i = 0; i < 30; i++) begin
            if (memoryWritebackValid) begin
                de = destinationEnable; wd = writeData; at = cycle;
                return;
            end
            @(negedge clock);
        end
        checks++; failures++;
        $display("FAIL beat_timeout: got no beat expected one within 30 cycles");
        de = 0; wd = 32'h0; at = -1;
    endtask

    initial begin
        int          acc, acc2, at, cnt;
        bit          bde;
        logic [31:0] bwd, prev;
        memoryOp_t   rop;
        logic [31:0] rres;

        executeValid = 0; executeResult = 0; executeStoreData = 0; executeMemoryOp = NONE;
        executeDestinationEnable = 0; executeWriteAddress = 0;
        dataRequestReady = 0; dataResponseValid = 0; dataResponseData = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        repeat (3) @(negedge clock);
        check("rst_ready", {31'h0, executeReady}, 32'h1);
        check("rst_beat_valid", {31'h0, memoryWritebackValid}, 32'h0);
        check("rst_dest_en", {31'h0, destinationEnable}, 32'h0);
        check("rst_req_valid", {31'h0, dataRequestValid}, 32'h0);
        check("rst_addr", dataAddress, 32'h0);
        check("rst_strobe", {28'h0, dataWriteStrobe}, 32'h0);
        check("rst_wdata", dataWriteData, 32'h0);
        check("rst_wr_data", writeData, 32'h0);
        check("rst_mis_addr", misalignedAddress, 32'h0);
        #2 reset = 1'b0;
        @(negedge clock);

        issue(NONE, 32'h1234, 32'h0, 1'b1, 5'd5, acc);
        check("alu_valid", {31'h0, memoryWritebackValid}, 32'h1);
        check("alu_dest_en", {31'h0, destinationEnable}, 32'h1);
        check("alu_wr_addr", {27'h0, writeAddress}, 32'd5);
        check("alu_wr_data", writeData, 32'h1234);
        issue(NONE, 32'h5678, 32'h0, 1'b1, 5'd6, acc2);
        check("alu_back_to_back", acc2, acc + 1);

        mem[0] = 32'h80FF_FF7F;
        issue(LB, 32'h1003, 32'h0, 1'b1, 5'd7, acc);
        check("lb_req_valid", {31'h0, dataRequestValid}, 32'h1);
        check("lb_req_addr", dataAddress, 32'h1000);
        check("lb_req_strobe", {28'h0, dataWriteStrobe}, 32'h0);
        wait_beat(bde, bwd, at);
        check("lb_data", bwd, 32'hFFFF_FF80);
        check("lb_latency", at, acc + 3);
        issue(LBU, 32'h1003, 32'h0, 1'b1, 5'd8, acc);
        wait_beat(bde, bwd, at);
        check("lbu_data", bwd, 32'h0000_0080);

        ready_hold = 3;
        issue(SH, 32'h2002, 32'hAAAA_BEEF, 1'b0, 5'd1, acc);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (memoryWritebackValid) break;
            if (dataRequestValid) begin
                cnt++;
                check("sh_strobe", {28'h0, dataWriteStrobe}, 32'hC);
                check("sh_data", dataWriteData, 32'hBEEF_BEEF);
            end
            @(negedge clock);
        end
        check("sh_req_cycles", cnt, 4);
        check("sh_beat_dest_en", {31'h0, destinationEnable}, 32'h0);
        check("sh_ready_back", {31'h0, executeReady}, 32'h1);

        issue(LW, 32'h3001, 32'h0, 1'b1, 5'd9, acc);
        check("mis_no_req", {31'h0, dataRequestValid}, 32'h0);
        check("mis_exception", {31'h0, misalignedException}, 32'h1);
        check("mis_addr", misalignedAddress, 32'h3001);
        check("mis_dest_en", {31'h0, destinationEnable}, 32'h0);

        issue(LW, 32'h10, 32'h0, 1'b1, 5'd0, acc);
        wait_beat(bde, bwd, at);
        check("rd0_dest_en", {31'h0, bde}, 32'h0);

        repeat (2) @(negedge clock);
        prev = writeData;
        spurious_force = 1;
        repeat (4) begin
            @(negedge clock);
            check("spur_no_beat", {31'h0, memoryWritebackValid}, 32'h0);
        end
        check("spur_wr_data", writeData, prev);

        resp_delay_fixed = 4;
        issue(LW, 32'h20, 32'h0, 1'b1, 5'd3, acc);
        for (int i = 0; i < 20; i++) begin
            if (!dataRequestValid && !executeReady) break;
            @(negedge clock);
        end
        #2 reset = 1'b1;
        exp_q.delete();
        req_q.delete();
        mem_outstanding = 0;
        exp_mis_addr = 32'h0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("rst_wait_ready", {31'h0, executeReady}, 32'h1);
        check("rst_wait_no_beat", {31'h0, memoryWritebackValid}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (!resp_pending) break;
            @(negedge clock);
        end
        repeat (3) @(negedge clock);

        resp_delay_fixed = -1;
        ready_rand = 1;
        spurious_en = 1;
        for (int n = 0; n < 300; n++) begin
            rop  = memoryOp_t'(4'($urandom_range(0, 8)));
            rres = (rop == NONE) ? $urandom : (($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 255)));
            issue(rop, rres, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), acc);
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !mem_outstanding) break;
            @(negedge clock);
        end
        checks++;
        if (exp_q.size() != 0 || mem_outstanding) begin
            failures++;
            $display("FAIL drain: got %0d beats outstanding expected 0", exp_q.size());
        end
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
